hex_counter_display: RTL
========================

HEX_COUNTER_DISPLAY -- requirements
Module: hex_counter_display

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_TIME_MS, default 10, meaning the button stable time; DB_CYC = CLK_FREQ_HZ/1000*DEBOUNCE_TIME_MS.
REQ-003 SHALL have parameter NUM_DIGITS, default 4, range 1..8, meaning the number of hex digits counted and displayed.
REQ-004 SHALL have parameter REFRESH_HZ, default 1000, meaning the full-display refresh rate; SCAN_CYC = CLK_FREQ_HZ/(REFRESH_HZ*NUM_DIGITS), minimum 1.
REQ-005 SHALL have parameter BLANK_LZ, default 0; when 1, leading zero digits are blanked.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = reset).
REQ-008 SHALL have port btn_inc, input, 1 bit, raw asynchronous increment button, active-high.
REQ-009 SHALL have port btn_dec, input, 1 bit, raw asynchronous decrement button, active-high.
REQ-010 SHALL have port load, input, 1 bit, synchronous load strobe.
REQ-011 SHALL have port load_value, input, 4*NUM_DIGITS bits, the value to load.
REQ-012 SHALL have port dp_in, input, NUM_DIGITS bits, per-digit decimal point, active-high.
REQ-013 SHALL have port an, output, NUM_DIGITS bits, digit enables, active-low one-hot.
REQ-014 SHALL have port sseg, output, 8 bits, {dp,g,f,e,d,c,b,a}, active-low.
REQ-015 SHALL have port count, output, 4*NUM_DIGITS bits, current counter value.
REQ-016 SHALL have port wrap, output, 1 bit, one-cycle pulse on counter wrap in either direction.

Function
REQ-017 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-018 SHALL debounce each synchronized button by updating its stable state only after the input differs from it for DB_CYC consecutive cycles; any shorter glitch restarts the count.
REQ-019 SHALL generate a one-cycle inc/dec pulse on each 0->1 transition of the debounced state only; holding a button produces exactly one pulse.
REQ-020 SHALL update count on the cycle after a pulse or load (1-cycle latency).
REQ-021 SHALL apply priority load > (inc XOR dec); inc and dec pulses in the same cycle leave count unchanged.
REQ-022 SHALL make count wrap modulo 16^NUM_DIGITS: all-F + 1 -> 0 and 0 - 1 -> all-F, each asserting wrap for exactly one cycle with the count change.
REQ-023 SHALL never assert wrap on a load, even when the loaded value equals a wrap target.
REQ-024 SHALL produce a scan tick every SCAN_CYC cycles from a free-running prescaler; on each tick the digit index advances by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-025 SHALL register an and sseg on scan ticks: an = ~(1<<idx), sseg[6:0] = active-low hex glyph of count digit idx, sseg[7] = ~dp_in[idx].
REQ-026 SHALL use these glyphs (sseg[6:0]): 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; the remaining glyphs are the standard hex set.
REQ-027 SHALL, when BLANK_LZ=1, force sseg[6:0]=1111111 for any digit above the most significant nonzero digit; digit 0 is never blanked; dp is unaffected.
REQ-028 SHALL let count changes appear on the display at the next tick that selects the affected digit.

Reset
REQ-029 SHALL, while reset=0, force count=0, wrap=0, an=all ones, sseg=8'hFF, idx=0, clear the prescaler and debounce counters, and clear synchronizers and debounced states to 0.
REQ-030 SHALL, after reset release, enable digit 0 on the first scan tick (SCAN_CYC cycles later).
REQ-031 SHALL abort any in-progress debounce on reset mid-operation; a button held through release produces one pulse after DB_CYC stable cycles.

Verification (CLK_FREQ_HZ=12000, DEBOUNCE_TIME_MS=1 -> DB_CYC=12, REFRESH_HZ=1000, NUM_DIGITS=4 -> SCAN_CYC=3)
REQ-032 SHALL cover debounce: btn_inc high 8 cycles, low, then high 40 cycles -> no change from the glitch, exactly one increment, count=0x0001.
REQ-033 SHALL cover wrap: load 0xFFFF, inc press -> count=0x0000 and wrap high for 1 cycle; dec press -> count=0xFFFF and wrap pulses again.
REQ-034 SHALL cover simultaneous events: inc and dec pulses in the same cycle -> count unchanged; load 0x1234 coincident with an inc pulse -> count=0x1234, wrap=0.
REQ-035 SHALL cover scanning: count=0x08A1, dp_in=4'b0010 -> an sequence 1110,1101,1011,0111 every 3 cycles; sseg = 11111001, 00001000, 10000000, 11000000.
REQ-036 SHALL cover blanking: BLANK_LZ=1, count=0x0000 -> digits 3..1 show sseg=8'hFF and digit 0 shows 11000000.
REQ-037 SHALL cover reset mid-operation: reset=0 mid-scan with count=0x00AB -> immediate count=0, an=1111, sseg=8'hFF; after release, digit 0 active 3 cycles later.

Source files
------------

// File: rtl/hex_counter_display.sv
// Up/down hex counter driven by debounced buttons, with a load port and a multiplexed,
// active-low seven-segment scanner with optional leading-zero blanking.
module hex_counter_display #(
  parameter int unsigned CLK_FREQ_HZ      = 12000000,
  parameter int unsigned DEBOUNCE_TIME_MS = 10,
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned REFRESH_HZ       = 1000,
  parameter bit          BLANK_LZ         = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_inc,
  input  logic                    btn_dec,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap
);

  localparam int unsigned DbRaw   = CLK_FREQ_HZ / 1000 * DEBOUNCE_TIME_MS;
  localparam int unsigned DbCyc   = (DbRaw < 1) ? 1 : DbRaw;
  localparam int unsigned ScanRaw = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned ScanCyc = (ScanRaw < 1) ? 1 : ScanRaw;
  localparam int unsigned DbW     = $clog2(DbCyc + 1);
  localparam int unsigned ScanW   = $clog2(ScanCyc + 1);
  localparam int unsigned IdxW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW    = 4 * NUM_DIGITS;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Index 0 = increment button, index 1 = decrement button.
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           stable_q, stable_d;
  logic [1:0]           pulse_q, pulse_d;
  logic [1:0][DbW-1:0]  db_cnt_q, db_cnt_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 wrap_q, wrap_d;
  logic [ScanW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]           sseg_q, sseg_d;
  logic                 tick;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      stable_d[b] = stable_q[b];
      pulse_d[b]  = 1'b0;
      db_cnt_d[b] = '0;
      // Any cycle where the input agrees with the stable state restarts the count.
      if (sync2_q[b] != stable_q[b]) begin
        if (db_cnt_q[b] == DbW'(DbCyc - 1)) begin
          stable_d[b] = sync2_q[b];
          pulse_d[b]  = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (pulse_q[0] ^ pulse_q[1]) begin
      if (pulse_q[0]) begin
        count_d = count_q + CntW'(1);
        wrap_d  = &count_q;
      end else begin
        count_d = count_q - CntW'(1);
        wrap_d  = ~|count_q;
      end
    end
  end

  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       upper_zero;

  always_comb begin
    tick       = (scan_cnt_q == ScanW'(ScanCyc - 1));
    scan_cnt_d = tick ? '0 : scan_cnt_q + ScanW'(1);
    idx_d      = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end

    cur_digit  = 4'h0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      an_d[d] = (IdxW'(d) != idx_q);
      if (IdxW'(d) == idx_q) begin
        cur_digit = count_q[4*d +: 4];
        cur_dp    = dp_in[d];
      end
      // Selected digit is blankable only if it and every digit above it are zero.
      if (d >= int'(idx_q) && count_q[4*d +: 4] != 4'h0) begin
        upper_zero = 1'b0;
      end
    end

    sseg_d[7] = ~cur_dp;
    if (BLANK_LZ && upper_zero && idx_q != '0) begin
      sseg_d[6:0] = 7'b1111111;
    end else begin
      sseg_d[6:0] = hex_glyph(cur_digit);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      pulse_q    <= '0;
      db_cnt_q   <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      sseg_q     <= 8'hFF;
    end else begin
      sync1_q    <= {btn_dec, btn_inc};
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      pulse_q    <= pulse_d;
      db_cnt_q   <= db_cnt_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      if (tick) begin
        an_q   <= an_d;
        sseg_q <= sseg_d;
      end
    end
  end

  assign an    = an_q;
  assign sseg  = sseg_q;
  assign count = count_q;
  assign wrap  = wrap_q;

endmodule
